mipi_rx_timing_ctrl: RTL and testbench

- Sequences the MIPI DSI receive video path. Decodes the receiver's command stream (data type + valid) into registered Vsync/Hsync pulses and a frame-active level.
- Gates the downstream pixel datapath so it starts only on a frame boundary.
- Counts active lines and frames, and flags sequence and line-count errors against the expected 1080-line format.
- Sits between the DSI packet receiver and the pixel re-timing/output stage.

---
 rtl/mipi_rx_pkg.sv | 18 +
 rtl/mipi_rx_pulse_gen.sv | 36 +++
 rtl/mipi_rx_timing_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mipi_rx_timing_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_rx_pkg.sv
// Shared definitions for the MIPI DSI receive timing controller.
//   DT_*     : DSI data-type codes seen on the receiver command stream
//   state_t  : sequencing states of the timing controller
package mipi_rx_pkg;

    localparam logic [5:0] DT_VSS    = 6'h01;
    localparam logic [5:0] DT_VSE    = 6'h11;
    localparam logic [5:0] DT_HSS    = 6'h21;
    localparam logic [5:0] DT_HSE    = 6'h31;
    localparam logic [5:0] DT_RGB888 = 6'h3E;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        WAIT_VSS = 2'd1,
        IN_FRAME = 2'd2
    } state_t;

endpackage

// File: rtl/mipi_rx_pulse_gen.sv
// Retriggerable fixed-length pulse generator.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   trigger : one-cycle request; pulse is high for WIDTH cycles starting next cycle
//   enable  : low clears any pulse in progress
//   pulse   : output pulse
module mipi_rx_pulse_gen #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    input  logic enable,
    output logic pulse
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;

    // A trigger during an active pulse reloads the count, stretching the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (trigger) begin
            cnt <= CW'(WIDTH);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/mipi_rx_timing_ctrl.sv
// MIPI DSI receive video timing controller.
// Decodes the receiver command stream into Vsync/Hsync pulses, a frame-active
// level and a pixel datapath gate; counts lines and frames; flags errors.
//   CLKn, RST            : clock, asynchronous active-high reset
//   En                   : block enable, low forces DISABLED
//   Rx_cmd_data_type/valid : packet header data type and its strobe
//   Err_clr              : clears sticky error flags
//   Vsync, Hsync         : timing pulses
//   Frame_active, Pix_en : frame level and pixel gate
//   Line_cnt, Last_line_cnt, Frame_cnt : line / frame accounting
//   Err_lines, Err_seq   : sticky error flags
//
// state    | meaning
// DISABLED | block off, waits for En
// WAIT_VSS | enabled, waiting for the first frame start
// IN_FRAME | inside a frame, lines are being counted
module mipi_rx_timing_ctrl
    import mipi_rx_pkg::*;
#(
    parameter int VS_WIDTH  = 6,
    parameter int HS_WIDTH  = 4,
    parameter int LINE_W    = 12,
    parameter int EXP_LINES = 1080
) (
    input  logic              CLKn,
    input  logic              RST,
    input  logic              En,
    input  logic [5:0]        Rx_cmd_data_type,
    input  logic              Rx_cmd_valid,
    input  logic              Err_clr,
    output logic              Vsync,
    output logic              Hsync,
    output logic              Frame_active,
    output logic              Pix_en,
    output logic [LINE_W-1:0] Line_cnt,
    output logic [LINE_W-1:0] Last_line_cnt,
    output logic [15:0]       Frame_cnt,
    output logic              Err_lines,
    output logic              Err_seq
);

    state_t            state, state_n;
    logic [LINE_W-1:0] line_cnt_n, last_line_n;
    logic [15:0]       frame_cnt_n;
    logic              line_open, line_open_n;
    logic              pix_seen, pix_seen_n;
    logic              err_lines_set, err_seq_set;
    logic              vs_trig, hs_trig;
    logic              is_vss, is_hss, is_pix;
    logic [LINE_W:0]   final_sum;
    logic [LINE_W-1:0] final_lines;

    assign is_vss = Rx_cmd_valid && (Rx_cmd_data_type == DT_VSS);
    assign is_hss = Rx_cmd_valid && (Rx_cmd_data_type == DT_HSS);
    assign is_pix = Rx_cmd_valid && (Rx_cmd_data_type == DT_RGB888);

    // A line still open with pixels counts toward the frame being closed.
    assign final_sum   = {1'b0, Line_cnt} + {{LINE_W{1'b0}}, (line_open & pix_seen)};
    assign final_lines = final_sum[LINE_W] ? '1 : final_sum[LINE_W-1:0];

    always_comb begin
        state_n       = state;
        line_cnt_n    = Line_cnt;
        last_line_n   = Last_line_cnt;
        frame_cnt_n   = Frame_cnt;
        line_open_n   = line_open;
        pix_seen_n    = pix_seen;
        err_lines_set = 1'b0;
        err_seq_set   = 1'b0;
        vs_trig       = 1'b0;
        hs_trig       = 1'b0;

        if (!En) begin
            // Disable wins over any command this cycle; no frame close.
            state_n     = DISABLED;
            line_cnt_n  = '0;
            line_open_n = 1'b0;
            pix_seen_n  = 1'b0;
        end else begin
            case (state)
                DISABLED: state_n = WAIT_VSS;
                WAIT_VSS: begin
                    if (is_vss) begin
                        state_n = IN_FRAME;
                        vs_trig = 1'b1;
                    end else if (is_pix) begin
                        err_seq_set = 1'b1;
                    end
                end
                IN_FRAME: begin
                    if (is_vss) begin
                        vs_trig     = 1'b1;
                        last_line_n = final_lines;
                        frame_cnt_n = Frame_cnt + 16'd1;
                        line_cnt_n  = '0;
                        line_open_n = 1'b0;
                        pix_seen_n  = 1'b0;
                        if (final_lines != LINE_W'(EXP_LINES)) begin
                            err_lines_set = 1'b1;
                        end
                    end else if (is_hss) begin
                        hs_trig = 1'b1;
                        if (line_open && pix_seen && (Line_cnt != '1)) begin
                            line_cnt_n = Line_cnt + LINE_W'(1);
                        end
                        line_open_n = 1'b1;
                        pix_seen_n  = 1'b0;
                    end else if (is_pix) begin
                        if (line_open && !pix_seen) begin
                            pix_seen_n = 1'b1;
                        end else begin
                            err_seq_set = 1'b1;
                        end
                    end
                end
                default: state_n = DISABLED;
            endcase
        end
    end

    always_ff @(posedge CLKn or posedge RST) begin
        if (RST) begin
            state         <= DISABLED;
            Line_cnt      <= '0;
            Last_line_cnt <= '0;
            Frame_cnt     <= '0;
            line_open     <= 1'b0;
            pix_seen      <= 1'b0;
            Frame_active  <= 1'b0;
            Pix_en        <= 1'b0;
            Err_lines     <= 1'b0;
            Err_seq       <= 1'b0;
        end else begin
            state         <= state_n;
            Line_cnt      <= line_cnt_n;
            Last_line_cnt <= last_line_n;
            Frame_cnt     <= frame_cnt_n;
            line_open     <= line_open_n;
            pix_seen      <= pix_seen_n;
            // Built from next-state so the levels line up with the state register.
            Frame_active  <= (state_n == IN_FRAME);
            Pix_en        <= (state_n == IN_FRAME) && line_open_n;
            Err_lines     <= err_lines_set | (Err_lines & ~Err_clr);
            Err_seq       <= err_seq_set | (Err_seq & ~Err_clr);
        end
    end

    mipi_rx_pulse_gen #(.WIDTH(VS_WIDTH)) u_vs_gen (
        .clk     (CLKn),
        .rst     (RST),
        .trigger (vs_trig),
        .enable  (En),
        .pulse   (Vsync)
    );

    mipi_rx_pulse_gen #(.WIDTH(HS_WIDTH)) u_hs_gen (
        .clk     (CLKn),
        .rst     (RST),
        .trigger (hs_trig),
        .enable  (En),
        .pulse   (Hsync)
    );

endmodule

// File: tb/tb_mipi_rx_timing_ctrl.sv
// Self-checking bench for mipi_rx_timing_ctrl: directed frames plus random
// command traffic, checked every cycle against a behavioural model.
module tb_mipi_rx_timing_ctrl;

    localparam int VS_W = 6;
    localparam int HS_W = 4;
    localparam int EXP  = 1080;
    localparam int LMAX = 4095;

    localparam logic [5:0] C_VSS = 6'h01;
    localparam logic [5:0] C_VSE = 6'h11;
    localparam logic [5:0] C_HSS = 6'h21;
    localparam logic [5:0] C_HSE = 6'h31;
    localparam logic [5:0] C_PIX = 6'h3E;

    logic        CLKn = 1'b0;
    logic        RST, En, Rx_cmd_valid, Err_clr;
    logic [5:0]  Rx_cmd_data_type;
    logic        Vsync, Hsync, Frame_active, Pix_en, Err_lines, Err_seq;
    logic [11:0] Line_cnt, Last_line_cnt;
    logic [15:0] Frame_cnt;

    int n_chk = 0;
    int n_err = 0;

    mipi_rx_timing_ctrl dut (
        .CLKn             (CLKn),
        .RST              (RST),
        .En               (En),
        .Rx_cmd_data_type (Rx_cmd_data_type),
        .Rx_cmd_valid     (Rx_cmd_valid),
        .Err_clr          (Err_clr),
        .Vsync            (Vsync),
        .Hsync            (Hsync),
        .Frame_active     (Frame_active),
        .Pix_en           (Pix_en),
        .Line_cnt         (Line_cnt),
        .Last_line_cnt    (Last_line_cnt),
        .Frame_cnt        (Frame_cnt),
        .Err_lines        (Err_lines),
        .Err_seq          (Err_seq)
    );

    always #5 CLKn = ~CLKn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pulses are modelled as "edge of last accepted trigger" versus "edge of
    // last disable": the output is high for VS_W/HS_W edges after a trigger.
    int e;
    int vs_trig_e, vs_kill_e, hs_trig_e, hs_kill_e;
    bit m_awake, m_inframe, m_open, m_seen, m_el, m_es;
    int m_lc, m_last, m_fc;

    task automatic model_reset();
        m_awake = 0; m_inframe = 0; m_open = 0; m_seen = 0; m_el = 0; m_es = 0;
        m_lc = 0; m_last = 0; m_fc = 0;
        vs_trig_e = -100; vs_kill_e = -50;
        hs_trig_e = -100; hs_kill_e = -50;
    endtask

    task automatic model_step();
        bit sl, ss, vss, hss, pix;
        int fin;
        sl  = 0; ss = 0;
        vss = Rx_cmd_valid && (Rx_cmd_data_type == C_VSS);
        hss = Rx_cmd_valid && (Rx_cmd_data_type == C_HSS);
        pix = Rx_cmd_valid && (Rx_cmd_data_type == C_PIX);
        if (!En) begin
            m_awake = 0; m_inframe = 0; m_open = 0; m_seen = 0; m_lc = 0;
            vs_kill_e = e; hs_kill_e = e;
        end else if (!m_awake) begin
            m_awake = 1;
        end else if (!m_inframe) begin
            if (vss) begin
                m_inframe = 1;
                vs_trig_e = e;
            end else if (pix) begin
                ss = 1;
            end
        end else begin
            if (vss) begin
                fin = m_lc + ((m_open && m_seen) ? 1 : 0);
                if (fin > LMAX) fin = LMAX;
                m_last = fin;
                if (fin != EXP) sl = 1;
                m_fc = (m_fc + 1) % 65536;
                m_lc = 0; m_open = 0; m_seen = 0;
                vs_trig_e = e;
            end else if (hss) begin
                if (m_open && m_seen && m_lc < LMAX) m_lc++;
                m_open = 1; m_seen = 0;
                hs_trig_e = e;
            end else if (pix) begin
                if (m_open && !m_seen) m_seen = 1;
                else ss = 1;
            end
        end
        m_el = sl || (m_el && !Err_clr);
        m_es = ss || (m_es && !Err_clr);
    endtask

    // Single compare process: model advances on each edge, outputs sampled 1ns later.
    initial e = 0;
    always @(posedge CLKn) begin
        e++;
        if (RST) model_reset();
        else     model_step();
        #1;
        chk("vsync",    32'(Vsync),        32'((vs_trig_e > vs_kill_e) && (e - vs_trig_e < VS_W)));
        chk("hsync",    32'(Hsync),        32'((hs_trig_e > hs_kill_e) && (e - hs_trig_e < HS_W)));
        chk("frame_active", 32'(Frame_active), 32'(m_inframe));
        chk("pix_en",   32'(Pix_en),       32'(m_inframe && m_open));
        chk("line_cnt", 32'(Line_cnt),     32'(m_lc));
        chk("last_line_cnt", 32'(Last_line_cnt), 32'(m_last));
        chk("frame_cnt", 32'(Frame_cnt),   32'(m_fc));
        chk("err_lines", 32'(Err_lines),   32'(m_el));
        chk("err_seq",  32'(Err_seq),      32'(m_es));
    end

    // ---------------- stimulus ----------------
    // One command per call, driven at negedge; returns 2ns after the sampling edge.
    task automatic step(input logic v, input logic [5:0] dt);
        @(negedge CLKn);
        Rx_cmd_valid     = v;
        Rx_cmd_data_type = dt;
        Err_clr          = 1'b0;
        @(posedge CLKn);
        #2;
    endtask

    task automatic clr_step();
        @(negedge CLKn);
        Rx_cmd_valid = 1'b0;
        Err_clr      = 1'b1;
        @(posedge CLKn);
        #2;
        @(negedge CLKn);
        Err_clr = 1'b0;
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, C_HSS);
            step(1'b1, C_PIX);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vsync"},  32'(Vsync), 0);
        chk({tag, "_hsync"},  32'(Hsync), 0);
        chk({tag, "_fa"},     32'(Frame_active), 0);
        chk({tag, "_pixen"},  32'(Pix_en), 0);
        chk({tag, "_lc"},     32'(Line_cnt), 0);
        chk({tag, "_last"},   32'(Last_line_cnt), 0);
        chk({tag, "_fc"},     32'(Frame_cnt), 0);
        chk({tag, "_errl"},   32'(Err_lines), 0);
        chk({tag, "_errs"},   32'(Err_seq), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        RST = 1'b1; En = 1'b0; Rx_cmd_valid = 1'b0; Rx_cmd_data_type = 6'h00; Err_clr = 1'b0;
        repeat (3) @(posedge CLKn);
        #2;
        chk_all_zero("reset");
        @(negedge CLKn);
        RST = 1'b0;
        En  = 1'b1;
        step(1'b0, 6'h00);             // DISABLED -> WAIT_VSS

        // HSS/PIX before any VSS
        step(1'b1, C_HSS);
        chk("pre_vss_hsync", 32'(Hsync), 0);
        step(1'b1, C_PIX);
        chk("pre_vss_errseq", 32'(Err_seq), 1);
        chk("pre_vss_fa", 32'(Frame_active), 0);
        step(1'b0, 6'h00);
        chk("pre_vss_hsync2", 32'(Hsync), 0);
        clr_step();
        chk("errseq_clr", 32'(Err_seq), 0);

        // Vsync / Hsync timing
        step(1'b1, C_VSS);
        chk("vs_k1", 32'(Vsync), 1);
        chk("fa_rise", 32'(Frame_active), 1);
        chk("pixen_before_hss", 32'(Pix_en), 0);
        for (int k = 2; k <= 7; k++) begin
            step(1'b0, 6'h00);
            chk($sformatf("vs_k%0d", k), 32'(Vsync), 32'(k <= VS_W));
        end
        step(1'b0, 6'h00);
        step(1'b0, 6'h00);
        step(1'b1, C_HSS);              // t+10
        chk("hs_k1", 32'(Hsync), 1);
        chk("pixen_rise", 32'(Pix_en), 1);
        for (int k = 2; k <= 5; k++) begin
            step(1'b0, 6'h00);
            chk($sformatf("hs_k%0d", k), 32'(Hsync), 32'(k <= HS_W));
        end

        // Full 1080-line frame (the opening VSS closes the empty frame above)
        step(1'b1, C_VSS);
        chk("pixen_fall", 32'(Pix_en), 0);
        chk("empty_frame_errl", 32'(Err_lines), 1);
        clr_step();
        for (int i = 0; i < 4; i++) step(1'b1, C_HSS);
        lines(1080);
        chk("lc_before_close", 32'(Line_cnt), 1079);
        step(1'b1, C_VSS);
        chk("full_last", 32'(Last_line_cnt), 1080);
        chk("full_fc", 32'(Frame_cnt), 2);
        chk("full_errl", 32'(Err_lines), 0);
        chk("full_lc", 32'(Line_cnt), 0);

        // 1079-line frame
        for (int i = 0; i < 4; i++) step(1'b1, C_HSS);
        lines(1079);
        step(1'b1, C_VSS);
        chk("short_last", 32'(Last_line_cnt), 1079);
        chk("short_errl", 32'(Err_lines), 1);
        chk("short_fc", 32'(Frame_cnt), 3);
        clr_step();
        chk("errl_clr", 32'(Err_lines), 0);

        // Two PIX in one line
        step(1'b1, C_HSS);
        step(1'b1, C_PIX);
        step(1'b1, C_PIX);
        chk("dbl_pix_errs", 32'(Err_seq), 1);
        step(1'b1, C_HSS);
        chk("dbl_pix_lc", 32'(Line_cnt), 1);

        // VSS retrigger three cycles after a VSS
        step(1'b1, C_VSS);
        step(1'b0, 6'h00);
        step(1'b0, 6'h00);
        step(1'b1, C_VSS);
        chk("vs_re_k1", 32'(Vsync), 1);
        for (int k = 2; k <= 7; k++) begin
            step(1'b0, 6'h00);
            chk($sformatf("vs_re_k%0d", k), 32'(Vsync), 32'(k <= VS_W));
        end
        chk("retrig_fc", 32'(Frame_cnt), 5);

        // Disable mid-frame at line 500
        lines(500);
        chk("mid_lc", 32'(Line_cnt), 499);
        chk("mid_pixen", 32'(Pix_en), 1);
        @(negedge CLKn);
        En = 1'b0;
        step(1'b0, 6'h00);
        chk("dis_pixen", 32'(Pix_en), 0);
        chk("dis_fa", 32'(Frame_active), 0);
        chk("dis_lc", 32'(Line_cnt), 0);
        chk("dis_fc", 32'(Frame_cnt), 5);
        chk("dis_last", 32'(Last_line_cnt), 0);
        @(negedge CLKn);
        En = 1'b1;
        step(1'b0, 6'h00);
        step(1'b1, C_VSS);
        chk("reen_fa", 32'(Frame_active), 1);
        chk("reen_fc", 32'(Frame_cnt), 5);
        lines(2);
        step(1'b1, C_VSS);
        chk("reen_last", 32'(Last_line_cnt), 2);
        chk("reen_fc2", 32'(Frame_cnt), 6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLKn);
            En               = ($urandom_range(0, 59) != 0);
            Err_clr          = ($urandom_range(0, 39) == 0);
            Rx_cmd_valid     = ($urandom_range(0, 9) < 7);
            r                = int'($urandom_range(0, 99));
            if      (r < 4)  Rx_cmd_data_type = C_VSS;
            else if (r < 35) Rx_cmd_data_type = C_HSS;
            else if (r < 75) Rx_cmd_data_type = C_PIX;
            else if (r < 82) Rx_cmd_data_type = C_VSE;
            else if (r < 89) Rx_cmd_data_type = C_HSE;
            else             Rx_cmd_data_type = 6'($urandom);
        end
        @(negedge CLKn);
        En = 1'b1; Err_clr = 1'b0; Rx_cmd_valid = 1'b0;
        repeat (2) step(1'b0, 6'h00);

        // Async reset in the middle of a Vsync pulse
        step(1'b1, C_VSS);
        step(1'b0, 6'h00);
        chk("pre_rst_vsync", 32'(Vsync), 1);
        #1;
        RST = 1'b1;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge CLKn);
        @(negedge CLKn);
        RST = 1'b0;
        repeat (3) step(1'b0, 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
